// File: rtl/axi_arbiter_r.sv
// Round-robin read-channel (AR/R) arbiter for four AXI masters.
// One transaction outstanding; the grant is held from the AR handshake through RLAST.
module axi_arbiter_r (
  input  logic       ACLK,
  input  logic       ARESETn,
  input  logic       m0_ARVALID,
  input  logic       m0_ARREADY,
  input  logic       m0_RVALID,
  input  logic       m0_RREADY,
  input  logic       m0_RLAST,
  input  logic       m1_ARVALID,
  input  logic       m1_ARREADY,
  input  logic       m1_RVALID,
  input  logic       m1_RREADY,
  input  logic       m1_RLAST,
  input  logic       m2_ARVALID,
  input  logic       m2_ARREADY,
  input  logic       m2_RVALID,
  input  logic       m2_RREADY,
  input  logic       m2_RLAST,
  input  logic       m3_ARVALID,
  input  logic       m3_ARREADY,
  input  logic       m3_RVALID,
  input  logic       m3_RREADY,
  input  logic       m3_RLAST,
  output logic       m0_rgrnt,
  output logic       m1_rgrnt,
  output logic       m2_rgrnt,
  output logic       m3_rgrnt,
  output logic [1:0] rd_owner,
  output logic       rd_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;

  logic [3:0] arvalid, arready, rvalid, rready, rlast;
  logic [1:0] sel;
  logic       found;

  assign arvalid = {m3_ARVALID, m2_ARVALID, m1_ARVALID, m0_ARVALID};
  assign arready = {m3_ARREADY, m2_ARREADY, m1_ARREADY, m0_ARREADY};
  assign rvalid  = {m3_RVALID,  m2_RVALID,  m1_RVALID,  m0_RVALID};
  assign rready  = {m3_RREADY,  m2_RREADY,  m1_RREADY,  m0_RREADY};
  assign rlast   = {m3_RLAST,   m2_RLAST,   m1_RLAST,   m0_RLAST};

  // Search owner+1 .. owner+4 (mod 4), so the current owner has lowest priority.
  always_comb begin
    sel   = owner_q;
    found = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      if (!found && arvalid[owner_q + 2'(i)]) begin
        sel   = owner_q + 2'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          if (sel != owner_q) begin
            owner_d = sel;
            state_d = ADDR;
          end else if (arready[owner_q]) begin
            state_d = DATA;
          end else begin
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        if (arvalid[owner_q] && arready[owner_q])
          state_d = DATA;
      end
      DATA: begin
        if (rvalid[owner_q] && rready[owner_q] && rlast[owner_q])
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  assign m0_rgrnt = (owner_q == 2'd0);
  assign m1_rgrnt = (owner_q == 2'd1);
  assign m2_rgrnt = (owner_q == 2'd2);
  assign m3_rgrnt = (owner_q == 2'd3);
  assign rd_owner = owner_q;
  assign rd_busy  = (state_q != IDLE);

endmodule
